// File: rtl/accum_sequencer_if.sv
// Command, accumulator and result signals of the accumulator sequencer.
// master is the sequencer side, slave is the environment side.
interface accum_sequencer_if;
  logic       In_Valid;
  logic       In_Ready;
  logic [3:0] In_Mode;
  logic [3:0] In_A;
  logic [3:0] In_B;
  logic       In_Cin;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] Mode;
  logic [3:0] Res;
  logic       Of;
  logic       Out_Valid;
  logic       Out_Ready;
  logic [3:0] Out_Res;
  logic       Out_Of;
  logic       Of_Sticky;
  logic       Clr_Of;
  logic [7:0] Op_Count;
  logic       Busy;

  modport master (
    input  In_Valid, In_Mode, In_A, In_B, In_Cin,
    input  Res, Of, Out_Ready, Clr_Of,
    output In_Ready, A, B, Cin, Mode,
    output Out_Valid, Out_Res, Out_Of,
    output Of_Sticky, Op_Count, Busy
  );

  modport slave (
    output In_Valid, In_Mode, In_A, In_B, In_Cin,
    output Res, Of, Out_Ready, Clr_Of,
    input  In_Ready, A, B, Cin, Mode,
    input  Out_Valid, Out_Res, Out_Of,
    input  Of_Sticky, Op_Count, Busy
  );
endinterface

// File: rtl/accum_sequencer.sv
// Command FIFO feeding a registered accumulator, one op per three cycles.
// Results are held until the consumer accepts them.
module accum_sequencer #(
  parameter int DEPTH = 4
) (
  input logic Clk,
  input logic Reset,
  accum_sequencer_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE, ISSUE, CAPTURE, HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [12:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      res_q;
  logic            of_q;
  logic            sticky_q, sticky_d;
  logic [7:0]      opc_q;
  logic [12:0]     head;
  logic            push, pop, hs;
  logic            empty, of_s;

  assign empty = (cnt_q == '0);
  assign bus.In_Ready = (cnt_q < CW'(DEPTH));
  assign push = bus.In_Valid & bus.In_Ready;
  assign pop  = (state_q == ISSUE);
  assign hs   = (state_q == HOLD) & bus.Out_Ready;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  // An undriven or unknown overflow line reads as no overflow
  always_comb begin
    of_s = 1'b0;
    if (bus.Of == 1'b1) of_s = 1'b1;
  end

  assign sticky_d = (sticky_q & ~bus.Clr_Of)
                  | ((state_q == CAPTURE) & of_s);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD:    if (hs) state_d = empty ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  assign head = mem_q[rd_q];
  assign {bus.Mode, bus.A, bus.B, bus.Cin} = pop ? head : 13'd0;

  assign bus.Out_Valid = (state_q == HOLD);
  assign bus.Out_Res   = res_q;
  assign bus.Out_Of    = of_q;
  assign bus.Of_Sticky = sticky_q;
  assign bus.Op_Count  = opc_q;
  assign bus.Busy      = (state_q != IDLE) | ~empty;

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_q] <= {bus.In_Mode, bus.In_A,
                              bus.In_B, bus.In_Cin};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      of_q     <= 1'b0;
      sticky_q <= 1'b0;
      opc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      if (state_q == CAPTURE) begin
        res_q <= bus.Res;
        of_q  <= of_s;
      end
      if (hs) opc_q <= opc_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer with a registered adder stub.
// Expected values are hand-computed A+B+Cin mod 16 with carry out.
module tb_accum_sequencer;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] acc_q;

  accum_sequencer_if bus ();

  accum_sequencer #(.DEPTH(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) acc_q <= '0;
    else acc_q <= {1'b0, bus.A} + {1'b0, bus.B}
                + {4'd0, bus.Cin};
  end
  assign bus.Res = acc_q[3:0];
  assign bus.Of  = acc_q[4];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [3:0] m, input logic [3:0] a,
                      input logic [3:0] b, input logic c);
    bus.In_Valid = 1'b1;
    bus.In_Mode = m;
    bus.In_A = a;
    bus.In_B = b;
    bus.In_Cin = c;
    tick();
    bus.In_Valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.Out_Valid && n < 50) begin
      tick();
      n++;
    end
    check("valid_tmo", 32'(bus.Out_Valid), 32'd1);
  endtask

  logic [3:0] va [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
  logic [3:0] vr [5] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
  logic       vrdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int n;
    bus.In_Valid = 1'b0;
    bus.In_Mode = '0;
    bus.In_A = '0;
    bus.In_B = '0;
    bus.In_Cin = 1'b0;
    bus.Out_Ready = 1'b0;
    bus.Clr_Of = 1'b0;
    #1;
    check("rst_ready", 32'(bus.In_Ready), 32'd1);
    check("rst_valid", 32'(bus.Out_Valid), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_opc", 32'(bus.Op_Count), 32'd0);
    check("rst_ab", 32'({bus.A, bus.B, bus.Mode, bus.Cin}), 32'd0);
    tick();
    tick();
    Reset = 1'b0;
    tick();

    // Basic op with latency and issue-cycle operands
    bus.Out_Ready = 1'b1;
    push(4'd0, 4'd3, 4'd4, 1'b1);
    check("busy_q", 32'(bus.Busy), 32'd1);
    tick();
    check("iss_a", 32'(bus.A), 32'd3);
    check("iss_b", 32'(bus.B), 32'd4);
    check("iss_cin", 32'(bus.Cin), 32'd1);
    tick();
    check("cap_valid", 32'(bus.Out_Valid), 32'd0);
    check("cap_a", 32'(bus.A), 32'd0);
    tick();
    check("hold_valid", 32'(bus.Out_Valid), 32'd1);
    check("res1", 32'(bus.Out_Res), 32'd8);
    check("of1", 32'(bus.Out_Of), 32'd0);
    tick();
    check("opc1", 32'(bus.Op_Count), 32'd1);
    check("idle_busy", 32'(bus.Busy), 32'd0);

    // Overflow, sticky flag and its clear
    bus.Out_Ready = 1'b0;
    push(4'd0, 4'd9, 4'd8, 1'b0);
    wait_valid(n);
    check("lat2", 32'(n), 32'd3);
    check("res2", 32'(bus.Out_Res), 32'd1);
    check("of2", 32'(bus.Out_Of), 32'd1);
    check("sticky_set", 32'(bus.Of_Sticky), 32'd1);
    bus.Out_Ready = 1'b1;
    tick();
    bus.Out_Ready = 1'b0;
    check("opc2", 32'(bus.Op_Count), 32'd2);
    check("sticky_keep", 32'(bus.Of_Sticky), 32'd1);
    bus.Clr_Of = 1'b1;
    tick();
    bus.Clr_Of = 1'b0;
    check("sticky_clr", 32'(bus.Of_Sticky), 32'd0);

    // Long hold with a queued command behind it
    push(4'd2, 4'd5, 4'd6, 1'b1);
    wait_valid(n);
    check("res3", 32'(bus.Out_Res), 32'd12);
    push(4'd1, 4'd1, 4'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_v", 32'(bus.Out_Valid), 32'd1);
      check("hold_r", 32'({bus.Out_Of, bus.Out_Res}), 32'd12);
      check("hold_a", 32'(bus.A), 32'd0);
    end
    bus.Out_Ready = 1'b1;
    tick();
    check("reiss_a", 32'(bus.A), 32'd1);
    check("reiss_m", 32'(bus.Mode), 32'd1);
    wait_valid(n);
    check("lat_reiss", 32'(n), 32'd2);
    check("res4", 32'(bus.Out_Res), 32'd2);
    tick();
    bus.Out_Ready = 1'b0;
    check("opc4", 32'(bus.Op_Count), 32'd4);

    // Fill the FIFO while a result is held
    for (int i = 0; i < 6; i++) begin
      bus.In_Valid = 1'b1;
      bus.In_Mode = '0;
      bus.In_A = va[i];
      bus.In_B = va[i];
      bus.In_Cin = 1'b0;
      check("fill_rdy", 32'(bus.In_Ready), 32'(vrdy[i]));
      tick();
    end
    bus.In_Valid = 1'b0;
    bus.Out_Ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(n);
      check("order", 32'(bus.Out_Res), 32'(vr[i]));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_extra", 32'(bus.Out_Valid), 32'd0);
    end
    check("drain_busy", 32'(bus.Busy), 32'd0);
    check("opc9", 32'(bus.Op_Count), 32'd9);

    // Asynchronous reset while capturing, with a queued command
    push(4'd0, 4'd7, 4'd7, 1'b0);
    push(4'd0, 4'd2, 4'd2, 1'b0);
    tick();
    check("pre_cap", 32'(bus.Out_Valid), 32'd0);
    #2;
    Reset = 1'b1;
    #1;
    check("ar_valid", 32'(bus.Out_Valid), 32'd0);
    check("ar_busy", 32'(bus.Busy), 32'd0);
    check("ar_ready", 32'(bus.In_Ready), 32'd1);
    check("ar_opc", 32'(bus.Op_Count), 32'd0);
    check("ar_res", 32'({bus.Out_Of, bus.Out_Res}), 32'd0);
    check("ar_ab", 32'({bus.A, bus.B, bus.Mode, bus.Cin}), 32'd0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ar_stale", 32'({bus.Out_Valid, bus.Busy}), 32'd0);
    end

    // Op_Count wraps after 256 deliveries
    for (int i = 0; i < 256; i++) begin
      push(4'd0, 4'(i), 4'd0, 1'b0);
      wait_valid(n);
      tick();
      if (i == 254) check("opc255", 32'(bus.Op_Count), 32'd255);
    end
    check("opc_wrap", 32'(bus.Op_Count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/accum_sequencer.md
ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

Interface
REQ-001 Parameter: DEPTH, default 4, number of command FIFO entries (power of 2, 2..16).
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 In_Valid  input  1  command offered.
REQ-005 In_Ready  output  1  command FIFO can accept.
REQ-006 In_Mode  input  4  operation code, passed through opaque.
REQ-007 In_A, In_B  input  4 each  operands.
REQ-008 In_Cin  input  1  carry-in.
REQ-009 A, B  output  4 each  operands driven to the accumulator.
REQ-010 Cin  output  1  carry-in driven to the accumulator.
REQ-011 Mode  output  4  mode driven to the accumulator.
REQ-012 Res  input  4  registered accumulator result.
REQ-013 Of  input  1  registered accumulator overflow; Z treated as 0.
REQ-014 Out_Valid  output  1  captured result available.
REQ-015 Out_Ready  input  1  consumer accepts result.
REQ-016 Out_Res  output  4  captured result.
REQ-017 Out_Of  output  1  captured overflow.
REQ-018 Of_Sticky  output  1  OR of all captured overflows since reset or clear.
REQ-019 Clr_Of  input  1  synchronous clear of Of_Sticky.
REQ-020 Op_Count  output  8  number of results delivered, wraps 255->0.
REQ-021 Busy  output  1  high whenever FSM is not IDLE or FIFO is non-empty.

Function
REQ-022 Command push: In_Valid & In_Ready writes {In_Mode,In_A,In_B,In_Cin} to FIFO tail.
REQ-023 In_Ready: 1 when FIFO count < DEPTH, from registered count; a same-cycle pop does not enable a push on full.
REQ-024 Push while In_Ready=0: ignored, FIFO unchanged.
REQ-025 FSM states: IDLE, ISSUE, CAPTURE, HOLD.
REQ-026 IDLE->ISSUE when FIFO non-empty; else stay.
REQ-027 ISSUE: one cycle; A/B/Cin/Mode driven from FIFO head; head popped at end of cycle; ->CAPTURE.
REQ-028 Outside ISSUE: A, B, Cin, Mode driven to 0.
REQ-029 CAPTURE: one cycle; Res and Of (Z/X->0) sampled into Out_Res/Out_Of at end of cycle; ->HOLD.
REQ-030 HOLD: Out_Valid=1; Out_Res/Out_Of stable; on Out_Valid & Out_Ready go ->ISSUE if FIFO non-empty, else ->IDLE.
REQ-031 Latency: command at FIFO head in IDLE -> Out_Valid high 3 cycles later; one op per 3 cycles at full throughput.
REQ-032 Op_Count increments by 1 on each Out_Valid & Out_Ready handshake, modulo 256.
REQ-033 Of_Sticky set at CAPTURE when sampled Of=1; Clr_Of clears it; clear and set in same cycle -> set wins.
REQ-034 Commands issued strictly in push order; none dropped or duplicated.
REQ-035 Out_Ready while Out_Valid=0: no effect.

Reset
REQ-036 Reset=1: FSM->IDLE, FIFO emptied, In_Ready=1, A=B=Mode=0, Cin=0, Out_Valid=0, Out_Res=0, Out_Of=0, Of_Sticky=0, Op_Count=0, Busy=0, immediately without a clock edge.
REQ-037 Reset mid-operation discards in-flight command and any held result; no Out_Valid after release until a new command is pushed.
REQ-038 First state change possible on first rising Clk edge after Reset deasserts.

Verification (accumulator stub: Res=A+B+Cin mod 16, Of=carry out, registered one cycle)
REQ-039 Push {Mode=0,A=3,B=4,Cin=1}, Out_Ready=1 -> Out_Valid 3 cycles after push accepted, Out_Res=8, Out_Of=0, Op_Count=1.
REQ-040 Push {A=9,B=8,Cin=0} -> Out_Res=1, Out_Of=1, Of_Sticky=1; then Clr_Of pulse -> Of_Sticky=0.
REQ-041 Out_Ready=0, push 5 commands with DEPTH=4 -> In_Ready low after FIFO full, extra push ignored; release Out_Ready -> exactly DEPTH+1 results in order (one popped pre-hold).
REQ-042 Out_Ready held 0 for 10 cycles in HOLD -> Out_Res/Out_Of unchanged, no new ISSUE.
REQ-043 Assert Reset during CAPTURE -> all outputs at reset values asynchronously, FIFO empty, no stale Out_Valid after release.
REQ-044 Deliver 256 results -> Op_Count wraps to 0.
